// File: rtl/alu_mul_seq.sv
// Issue sequencer for the shared execute-stage ALU: passes single-cycle ops through
// and runs MUL as an iterative shift-add on the ALU adder. Optional: MUL_EARLY_EXIT_EN.
module alu_mul_seq #(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = 32,
  parameter int OP_W      = 4,
  parameter logic [OP_W-1:0] ALUOP_ADD = 'd1,
  parameter logic [OP_W-1:0] ALUOP_MUL = 'd5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic [DATA_W-1:0] req_imm,
  output logic              req_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [DATA_W-1:0] alu_imm,
  input  logic [DATA_W-1:0] alu_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              stall
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  localparam logic [5:0] LAST_STEP = 6'(MUL_STEPS - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              last_step;

`ifdef MUL_EARLY_EXIT_EN
  // No set bits left in the multiplier means further steps would only add zero.
  assign last_step = ((mplier_q >> 1) == '0) || (cnt_q == LAST_STEP);
`else
  assign last_step = (cnt_q == LAST_STEP);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    stall     = 1'b0;
    alu_op    = '0;
    alu_src1  = '0;
    alu_src2  = '0;
    alu_imm   = '0;
    res_valid = 1'b0;
    res_data  = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        alu_op    = req_op;
        alu_src1  = req_src1;
        alu_src2  = req_src2;
        alu_imm   = req_imm;
        if (req_valid) begin
          if (req_op == ALUOP_MUL) begin
            acc_d    = '0;
            mcand_d  = req_src1;
            mplier_d = req_src2;
            cnt_d    = '0;
`ifdef MUL_EARLY_EXIT_EN
            state_d  = (req_src2 == '0) ? S_DONE : S_MUL;
`else
            state_d  = S_MUL;
`endif
          end else begin
            res_valid = 1'b1;
            res_data  = alu_data;
          end
        end
      end

      S_MUL: begin
        // One shift-add step per cycle; the ALU adder accumulates the partial product.
        stall    = 1'b1;
        alu_op   = ALUOP_ADD;
        alu_src1 = acc_q;
        alu_src2 = mplier_q[0] ? mcand_q : '0;
        acc_d    = alu_data;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (last_step) state_d = S_DONE;
      end

      S_DONE: begin
        res_valid = 1'b1;
        res_data  = acc_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Reset forces quiet outputs and aborts any multiply without a result pulse.
    if (!rst) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      mcand_d   = '0;
      mplier_d  = '0;
      cnt_d     = '0;
      req_ready = 1'b0;
      stall     = 1'b0;
      alu_op    = '0;
      alu_src1  = '0;
      alu_src2  = '0;
      alu_imm   = '0;
      res_valid = 1'b0;
      res_data  = '0;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU; honours MUL_EARLY_EXIT_EN.
module tb_alu_mul_seq;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src1, req_src2, req_imm;
  logic        req_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_src1, alu_src2, alu_imm;
  logic [31:0] alu_data;
  logic        res_valid;
  logic [31:0] res_data;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(
    .DATA_W(32), .MUL_STEPS(32), .OP_W(4), .ALUOP_ADD(OP_ADD), .ALUOP_MUL(OP_MUL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_imm(req_imm),
    .req_ready(req_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_imm(alu_imm),
    .alu_data(alu_data),
    .res_valid(res_valid), .res_data(res_data), .stall(stall)
  );

  // Behavioural combinational ALU
  always_comb begin
    alu_data = 32'h0;
    case (alu_op)
      OP_ADD:  alu_data = alu_src1 + alu_src2;
      OP_SUB:  alu_data = alu_src1 - alu_src2;
      OP_ORI:  alu_data = alu_src1 | alu_imm;
      OP_ADDI: alu_data = alu_src1 + alu_imm;
      default: alu_data = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [3:0] op,
                         input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm);
    req_valid = v;
    req_op    = op;
    req_src1  = s1;
    req_src2  = s2;
    req_imm   = imm;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] imm, input logic [31:0] exp);
    set_req(1'b1, op, s1, s2, imm);
    #1;
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_data"}, res_data, exp);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    cyc();
  endtask

  // Accept a MUL at t, then walk t+1..t+lat and the following IDLE cycle.
  task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit hold_add);
    int early;
    early = 0;
    set_req(1'b1, OP_MUL, a, b, 32'h0);
    #1;
    chk({tag, "_acc_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_acc_rv"}, 32'(res_valid), 32'd0);
    chk({tag, "_acc_stall"}, 32'(stall), 32'd0);
    cyc();
    if (hold_add) set_req(1'b1, OP_ADD, 32'd10, 32'd20, 32'h0);
    else          set_req(1'b0, OP_ADD, 32'h0, 32'h0, 32'h0);
    for (int k = 1; k <= lat; k++) begin
      #1;
      chk({tag, "_stall"}, 32'(stall), (k < lat) ? 32'd1 : 32'd0);
      chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
      if (k == 1 && lat > 1) begin
        chk({tag, "_step_op"}, 32'(alu_op), 32'(OP_ADD));
        chk({tag, "_step_src1"}, alu_src1, 32'h0);
      end
      if (k < lat && res_valid) early++;
      if (k == lat) begin
        chk({tag, "_done_rv"}, 32'(res_valid), 32'd1);
        chk({tag, "_done_data"}, res_data, exp);
      end
      cyc();
    end
    chk({tag, "_early_rv"}, 32'(early), 32'd0);
    #1;
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    if (hold_add) begin
      chk({tag, "_held_rv"}, 32'(res_valid), 32'd1);
      chk({tag, "_held_data"}, res_data, 32'd30);
    end else begin
      chk({tag, "_idle_rv"}, 32'(res_valid), 32'd0);
    end
    cyc();
    set_req(1'b0, OP_ADD, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int pulses;
    rst = 1'b0;
    set_req(1'b1, OP_ADD, 32'd5, 32'd3, 32'd7);
    cyc();
    cyc();
    // Reset holds every output low, even with a request presented
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_aluop", 32'(alu_op), 32'd0);
    chk("rst_src1", alu_src1, 32'h0);
    chk("rst_data", res_data, 32'h0);
    rst = 1'b1;
    set_req(1'b0, OP_ADD, 32'h0, 32'h0, 32'h0);
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    cyc();

    // Back-to-back single-cycle ops
    single("add", OP_ADD, 32'd5, 32'd3, 32'h0, 32'd8);
    single("sub", OP_SUB, 32'd3, 32'd5, 32'h0, 32'hFFFF_FFFE);
    single("ori", OP_ORI, 32'h0000_00F0, 32'h0, 32'h0000_000F, 32'h0000_00FF);
    single("addi", OP_ADDI, 32'd100, 32'h0, 32'd23, 32'd123);
    set_req(1'b0, OP_ADD, 32'h0, 32'h0, 32'h0);
    cyc();

    mul_run("mul7x6", 32'd7, 32'd6, 32'd42, EE ? 4 : 33, 1'b0);
    mul_run("mulwrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);
    mul_run("mulmsb", 32'h8000_0000, 32'd2, 32'h0, EE ? 3 : 33, 1'b0);
    mul_run("mulzero", 32'd123, 32'd0, 32'h0, EE ? 1 : 33, 1'b0);
    mul_run("busy", 32'd3, 32'd4, 32'd12, EE ? 4 : 33, 1'b1);

    // Reset in the middle of a full-length multiply
    set_req(1'b1, OP_MUL, 32'd9, 32'hFFFF_FFFF, 32'h0);
    cyc();
    set_req(1'b0, OP_ADD, 32'h0, 32'h0, 32'h0);
    repeat (9) cyc();
    #1;
    chk("mid_busy_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_aluop", 32'(alu_op), 32'd0);
    chk("midrst_src1", alu_src1, 32'h0);
    chk("midrst_src2", alu_src2, 32'h0);
    chk("midrst_rv", 32'(res_valid), 32'd0);
    cyc();
    rst = 1'b1;
    #1;
    chk("postrst_ready", 32'(req_ready), 32'd1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (res_valid || stall) pulses++;
      cyc();
    end
    chk("postrst_quiet", 32'(pulses), 32'd0);
    single("add11", OP_ADD, 32'd1, 32'd1, 32'h0, 32'd2);
    set_req(1'b0, OP_ADD, 32'h0, 32'h0, 32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequencer and issue controller for the shared execute-stage `ALU`, placed between DEC_ALU and the ALU. Single-cycle ops (ORI/ADDI/ADD/SUB) pass straight through to the ALU. `ALUop_MUL` runs as an iterative shift-add multiply that reuses the ALU adder for one step per cycle. While a multiply is in progress, the block stalls decode.

## Interface
- `MUL_STEPS`, default 32: maximum multiply iterations; equals the data width.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: decode presents an operation.
- `req_op`  in  `` `ALUControlBus ``: operation code. `ALUop_MUL` is a new code in define.v.
- `req_src1`, `req_src2`, `req_imm`  in  `` `DataSize ``: operands from DEC_ALU.
- `req_ready`  out  1: request accepted when `req_valid & req_ready`.
- `alu_op`  out  `` `ALUControlBus ``: op driven to the ALU.
- `alu_src1`, `alu_src2`, `alu_imm`  out  `` `DataSize ``: operands driven to the ALU.
- `alu_data`  in  `` `DataSize ``: ALU result (combinational).
- `res_valid`  out  1: `res_data` is valid this cycle.
- `res_data`  out  `` `DataSize ``: result to ALU_MEM.
- `stall`  out  1: freeze decode/fetch.

## Operation
- **States:** IDLE, MUL, DONE. State and registers are `acc`, `mcand`, `mplier` (all `` `DataSize ``) and `cnt` (6 bits).
- **IDLE**
  - `req_ready`=1.
  - `alu_*` = `req_*` (combinational pass-through).
  - If `req_valid` and op≠MUL: `res_valid`=1 and `res_data`=`alu_data` in the same cycle. Stay in IDLE.
  - If `req_valid` and op=MUL: latch `acc`←0, `mcand`←`req_src1`, `mplier`←`req_src2`, `cnt`←0. Go to MUL. `res_valid`=0 this cycle.
- **MUL** (each cycle)
  - Outputs: `alu_op`=`ALUop_ADD`, `alu_src1`=`acc`, `alu_src2`=`mplier[0] ? mcand : 0`, `alu_imm`=0.
  - Register updates: `acc`←`alu_data`, `mcand`←`mcand<<1`, `mplier`←`mplier>>1`, `cnt`←`cnt+1`.
  - Leave MUL for DONE after step `cnt`=`MUL_STEPS`-1 (early exit under Configuration).
  - `stall`=1, `req_ready`=0.
- **DONE**
  - `res_valid`=1, `res_data`=`acc`.
  - `stall`=0, `req_ready`=0.
  - `alu_op`=0, `alu_src*`=`` `DataBusReset ``.
  - Next state is IDLE.
- **Arithmetic:** result is the low 32 bits of the product, mod 2^32. It is identical for signed and unsigned operands. Adder carry-out is discarded.
- `req_valid` while in MUL or DONE is ignored. Decode holds the request, since `stall`=1 in MUL.
- **Reset** (`rst`=0 at a clock edge, in any state including mid-MUL):
  - Next state is IDLE; `acc`, `mcand`, `mplier`, `cnt` clear to 0.
  - No `res_valid` is produced for the aborted multiply.
  - While `rst`=0, outputs are forced: `req_ready`=0, `res_valid`=0, `stall`=0, `alu_op`=0, `alu_src*`/`res_data`=0.

## Timing
- Single-cycle op: 0-cycle latency. Result appears in the acceptance cycle, back-to-back every cycle.
- MUL accepted at cycle t:
  - Steps execute at t+1..t+32.
  - DONE / `res_valid` at t+33.
  - Next acceptance possible at t+34.
- `stall` is high at t+1..t+32 and low at t and t+33.
- At most one `res_valid` pulse per accepted request.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - MUL leaves for DONE after any step whose shifted `mplier` is 0.
  - If `req_src2`=0 at acceptance, the next state is DONE directly, at t+1, with result 0.
  - Latency is t + (index of highest set bit of `req_src2` + 1) + 1.
- Undefined: always exactly `MUL_STEPS` steps, regardless of operand values.

## Test plan
- **Single-cycle pass-through:** ADD 5,3 with `req_valid` → `res_valid`=1 and `res_data`=8 in the same cycle. Follow with SUB 3,5 next cycle → 0xFFFFFFFE.
- **Basic multiply:** MUL 7×6 accepted at t.
  - Without EN: `stall` high t+1..t+32, `res_valid` at t+33 with 42.
  - With EN: 3 steps, `res_valid` at t+4 with 42.
- **Wrap-around:** MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. MUL 0x80000000×2 → 0.
- **Zero multiplier:** MUL 123×0 → 0. With EN, `res_valid` at t+1. Without EN, `res_valid` at t+33.
- **Reset mid-op:** `rst`=0 at t+10 of a MUL → IDLE with all outputs 0 and no `res_valid`. Then ADD 1,1 → 2.
- **Busy handling:** `req_valid` with ADD held during MUL → `req_ready`=0 through DONE. The ADD is accepted in IDLE at t+34 with the correct result, and exactly one `res_valid` appears per request.
